// File: rtl/avg_pkg.sv
// Shared constants for the closest-to-average filter and its result FIFO.
package avg_pkg;
  localparam int DATA_W       = 16;
  localparam int WIN_LEN      = 12;
  localparam int DROP_CNT_W   = 8;
  localparam int DROP_CNT_MAX = 255;
endpackage

// File: rtl/avg_fifo_mem.sv
// Result storage: DEPTH x DATA_W register array, one write port, async read port.
module avg_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/avg_result_fifo.sv
// Show-ahead FIFO capturing filtered results; drops and counts words arriving while full.
module avg_result_fifo
  import avg_pkg::*;
#(
  parameter int DATA_W = avg_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  input  logic                  clr_ovf,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // Handshake: a word moves to the consumer on any posedge where out_valid and
  // out_ready are both high; out_valid never looks at out_ready, and the head
  // word is held until that transfer happens.

  localparam logic [AW:0]           DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX_C = DROP_CNT_W'(DROP_CNT_MAX);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count_nxt;
  logic [DATA_W-1:0] rdata;
  logic              push, pop, drop;

  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (!full | pop);
  assign drop      = in_valid & full & !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // full/empty are registered from the next count so they never depend on
  // pointer equality, which is ambiguous when the pointers wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)
        drop_cnt <= DROP_CNT_W'(1);
      else if (drop_cnt != DROP_MAX_C)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  avg_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  assign out_data = empty ? '0 : rdata;

endmodule

// File: tb/tb_avg_result_fifo.sv
// Self-checking bench for avg_result_fifo: directed vector table, corner sequences, random traffic.
module tb_avg_result_fifo;
  import avg_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              clr_ovf;
  logic              overflow;
  logic [7:0]        drop_cnt;

  avg_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .clr_ovf  (clr_ovf),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: plain queue of stored words plus overflow bookkeeping
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf;
  logic [7:0]        exp_dcnt;

  typedef struct {
    logic        iv;
    logic [15:0] data;
    logic        rdy;
    logic        clr;
    int          e_count;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_ovf;
    int          e_dcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int sz;
    bit do_pop;
    bit do_drop;
    sz      = exp_q.size();
    do_pop  = (sz != 0) && out_ready;
    do_drop = in_valid && (sz == DEPTH) && !do_pop;
    if (do_pop) void'(exp_q.pop_front());
    if (in_valid && !do_drop) exp_q.push_back(in_data);
    if (do_drop) begin
      exp_ovf  = 1'b1;
      exp_dcnt = clr_ovf ? 8'd1 : ((exp_dcnt == 8'd255) ? 8'd255 : exp_dcnt + 8'd1);
    end else if (clr_ovf) begin
      exp_ovf  = 1'b0;
      exp_dcnt = 8'd0;
    end
  endtask

  task automatic check_model();
    int sz;
    sz = exp_q.size();
    check("count", 32'(count), 32'(sz));
    check("empty", 32'(empty), 32'(sz == 0));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("out_data", 32'(out_data), (sz != 0) ? 32'(exp_q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_dcnt));
  endtask

  // driver: apply inputs for one clock, advance the model, sample after the edge
  task automatic cycle(input logic iv, input logic [15:0] d, input logic rdy, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic add_vec(input logic iv, input logic [15:0] d, input logic rdy, input logic clr,
                         input int ec, input logic ev, input logic [15:0] ed,
                         input logic eo, input int edc);
    vec_t v;
    v.iv = iv; v.data = d; v.rdy = rdy; v.clr = clr;
    v.e_count = ec; v.e_valid = ev; v.e_data = ed; v.e_ovf = eo; v.e_dcnt = edc;
    vecs.push_back(v);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    exp_ovf   = 1'b0;
    exp_dcnt  = 8'd0;

    // directed table: single word, fill, drop, drain, wrap, full push+pop
    add_vec(1, 16'h1234, 0, 0, 1, 1, 16'h1234, 0, 0);
    add_vec(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0);
    for (int i = 1; i <= 8; i++) add_vec(1, 16'(i), 0, 0, i, 1, 16'h0001, 0, 0);
    add_vec(1, 16'h0009, 0, 0, 8, 1, 16'h0001, 1, 1);
    for (int i = 1; i <= 8; i++)
      add_vec(0, 16'h0000, 1, 0, 8 - i, (i < 8), (i < 8) ? 16'(i + 1) : 16'h0000, 1, 1);
    for (int i = 0; i < 3; i++) add_vec(1, 16'(16'h000A + i), 0, 0, i + 1, 1, 16'h000A, 1, 1);
    add_vec(0, 16'h0000, 1, 0, 2, 1, 16'h000B, 1, 1);
    add_vec(0, 16'h0000, 1, 0, 1, 1, 16'h000C, 1, 1);
    add_vec(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 1);
    for (int i = 1; i <= 8; i++) add_vec(1, 16'(i), 0, 0, i, 1, 16'h0001, 1, 1);
    for (int i = 0; i < 4; i++) add_vec(1, 16'(16'h0100 + i), 1, 0, 8, 1, 16'(i + 2), 1, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0000);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].iv, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_dcnt", i), 32'(drop_cnt), 32'(vecs[i].e_dcnt));
    end

    // saturation of drop_cnt, then clear with and without a colliding drop
    for (int i = 0; i < 300; i++) cycle(1, 16'(i), 0, 0);
    check("sat_dcnt", 32'(drop_cnt), 32'd255);
    check("sat_ovf", 32'(overflow), 32'd1);
    cycle(1, 16'hBEEF, 0, 1);
    check("clr_drop_ovf", 32'(overflow), 32'd1);
    check("clr_drop_dcnt", 32'(drop_cnt), 32'd1);
    cycle(0, 16'h0000, 0, 1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_dcnt", 32'(drop_cnt), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 31) == 0);

    // reset mid-stream: drain (bounded), load five words, reset between edges
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) cycle(0, 16'h0000, 1, 0);
    check("drain_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1, 16'(16'h0050 + i), 0, 0);
    check("mid_count", 32'(count), 32'd5);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_data", 32'(out_data), 32'h0000);
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_dcnt = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1, 16'h00AA, 0, 0);
    check("post_rst_head", 32'(out_data), 32'h00AA);
    check("post_rst_count", 32'(count), 32'd1);
    cycle(0, 16'h0000, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
